bcd_chain_counter: RTL and testbench

Parametrised, cascaded multi-digit BCD counter for the stopwatch datapath, and the successor to the single-digit BCD counter. It counts one or more BCD digits on `clk5` under `enable`. Any digit can be set to count modulo 6, which supports seconds/minutes fields. It adds up/down counting, clear, parallel load and a full-chain wrap pulse, and its output feeds the display multiplexer directly.

---
 rtl/bcd_chain_counter.sv | 108 ++++++++++
 tb/tb_bcd_chain_counter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: cascaded multi-digit BCD counter for the stopwatch datapath.
// Each digit counts 0-9, or 0-5 where its SIX_MASK bit is set. The counter supports
// up/down counting, synchronous clear, parallel load and a one-cycle full-chain
// wrap pulse.
// The optional lap-freeze display is enabled by defining BCD_CHAIN_LAP_EN.

// Per-digit next-state logic. It is purely combinational; the top registers all digits.
module bcd_chain_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up,
  input  logic [3:0] q,
  output logic [3:0] nxt
);
  // Priority: clear > load > step > hold. An out-of-range load nibble becomes 0.
  always_comb begin
    nxt = q;
    if (clear)
      nxt = 4'd0;
    else if (load)
      nxt = (load_nib > MAX) ? 4'd0 : load_nib;
    else if (step)
      nxt = up ? ((q == MAX)  ? 4'd0 : q + 4'd1)
               : ((q == 4'd0) ? MAX  : q - 4'd1);
  end
endmodule

module bcd_chain_counter #(
  parameter int                DIGITS   = 4,
  parameter logic [DIGITS-1:0] SIX_MASK = DIGITS'(4'b0100)
) (
  input  logic                  clk5,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
`ifdef BCD_CHAIN_LAP_EN
  input  logic                  lap,
  output logic                  lap_active,
`endif
  output logic                  ovwOutput
);
  logic [DIGITS-1:0][3:0] cnt, cnt_nxt, ld;
  // lo_max[i] / lo_zero[i]: every digit below i sits at MAX / 0.
  logic [DIGITS:0]        lo_max, lo_zero;
  logic                   wrap;

  assign ld         = load_value;
  assign lo_max[0]  = 1'b1;
  assign lo_zero[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam logic [3:0] MX = SIX_MASK[i] ? 4'd5 : 4'd9;
    assign lo_max[i+1]  = lo_max[i]  & (cnt[i] == MX);
    assign lo_zero[i+1] = lo_zero[i] & (cnt[i] == 4'd0);
    bcd_chain_digit #(.MAX(MX)) u_dig (
      .clear    (clear),
      .load     (load),
      .load_nib (ld[i]),
      .step     (enable & (up ? lo_max[i] : lo_zero[i])),
      .up       (up),
      .q        (cnt[i]),
      .nxt      (cnt_nxt[i])
    );
  end

  // A full-chain wrap happens when every digit rolls over together.
  assign wrap = enable & ~clear & ~load & (up ? lo_max[DIGITS] : lo_zero[DIGITS]);

  // Register the digit chain and the wrap pulse on the same edge.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      ovwOutput <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      ovwOutput <= wrap;
    end
  end

`ifdef BCD_CHAIN_LAP_EN
  logic [DIGITS-1:0][3:0] lap_reg;

  // Each lap strobe toggles the freeze. Entering the freeze snapshots the post-edge count.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      lap_active <= 1'b0;
      lap_reg    <= '0;
    end else if (clear) begin
      lap_active <= 1'b0;
    end else if (lap) begin
      if (!lap_active) lap_reg <= cnt_nxt;
      lap_active <= ~lap_active;
    end
  end

  assign value = lap_active ? lap_reg : cnt;
`else
  assign value = cnt;
`endif
endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench for bcd_chain_counter (DIGITS=4, SIX_MASK=4'b0100: digit 2 counts 0-5).
module tb_bcd_chain_counter;
  logic        clk5 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] value;
  logic        ovwOutput;
`ifdef BCD_CHAIN_LAP_EN
  logic        lap = 1'b0;
  logic        lap_active;
`endif

  int tests = 0;
  int fails = 0;

  bcd_chain_counter #(.DIGITS(4), .SIX_MASK(4'b0100)) dut (
    .clk5       (clk5),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .value      (value),
`ifdef BCD_CHAIN_LAP_EN
    .lap        (lap),
    .lap_active (lap_active),
`endif
    .ovwOutput  (ovwOutput)
  );

  always #5 clk5 = ~clk5;

  typedef struct {
    logic        clr, ld, en, up;
    logic [15:0] lv;
    logic [15:0] exp_val;
    logic        exp_ovw;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic c, input logic l, input logic e, input logic u,
                       input logic [15:0] lv);
    clear = c; load = l; enable = e; up = u; load_value = lv;
    @(posedge clk5); #1;
  endtask

  initial begin
    //              clr ld en up   lv        value    ovw
    vecs.push_back('{0, 1, 0, 1, 16'h0598, 16'h0598, 1'b0});
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h0599, 1'b0});
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h1000, 1'b0}); // digit 2 wraps after 5
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0599, 1'b0}); // 1000 down
    vecs.push_back('{0, 1, 0, 1, 16'h0958, 16'h0058, 1'b0}); // digit 2 = 9 > 5 loads 0
    vecs.push_back('{0, 1, 0, 1, 16'h9599, 16'h9599, 1'b0});
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h0000, 1'b1}); // full wrap up
    vecs.push_back('{0, 0, 0, 1, 16'h0000, 16'h0000, 1'b0}); // pulse lasts one cycle
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h9599, 1'b1}); // full wrap down
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h9598, 1'b0});
    vecs.push_back('{1, 1, 1, 1, 16'h1234, 16'h0000, 1'b0}); // clear wins
    vecs.push_back('{0, 1, 0, 1, 16'h07A3, 16'h0003, 1'b0}); // invalid nibbles -> 0
    vecs.push_back('{0, 0, 0, 1, 16'h0000, 16'h0003, 1'b0});
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h0004, 1'b0});
    vecs.push_back('{0, 1, 1, 1, 16'h1234, 16'h1234, 1'b0}); // load beats enable
    vecs.push_back('{1, 0, 0, 1, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h9599, 1'b1}); // down from clear
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{0, 1, 0, 1, 16'h0009, 16'h0009, 1'b0});
    vecs.push_back('{0, 0, 1, 1, 16'h0000, 16'h0010, 1'b0});
    vecs.push_back('{0, 0, 1, 0, 16'h0000, 16'h0009, 1'b0});

    // Reset values while held in reset.
    #2;
    chk("reset_value", value, 16'h0000);
    chk("reset_ovw", {15'd0, ovwOutput}, 16'h0000);
`ifdef BCD_CHAIN_LAP_EN
    chk("reset_lap_active", {15'd0, lap_active}, 16'h0000);
`endif
    #10 reset = 1'b0;
    @(negedge clk5);

    // Leaving reset: first enabled edge counts.
    apply(0, 0, 1, 1, 16'h0000);
    chk("first_count", value, 16'h0001);

    // Table-driven vectors.
    foreach (vecs[k]) begin
      apply(vecs[k].clr, vecs[k].ld, vecs[k].en, vecs[k].up, vecs[k].lv);
      chk($sformatf("vec%0d_value", k), value, vecs[k].exp_val);
      chk($sformatf("vec%0d_ovw", k), {15'd0, ovwOutput}, {15'd0, vecs[k].exp_ovw});
    end

    // Asynchronous reset mid-cycle with a non-zero count and a live wrap pulse.
    apply(0, 1, 0, 1, 16'h9599);
    apply(0, 0, 1, 1, 16'h0000);           // ovwOutput now high
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ovw", {15'd0, ovwOutput}, 16'h0000);
    apply(0, 0, 0, 1, 16'h0000);
    reset = 1'b0;
    apply(0, 1, 0, 1, 16'h1234);
    apply(0, 0, 1, 1, 16'h0000);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_value", value, 16'h0000);
    #3 reset = 1'b0;
    #4;

    // Enable toggling over a 900 ns window: count holds while enable is low.
    begin
      int n = 0;
      apply(1, 0, 0, 1, 16'h0000);
      for (int c = 0; c < 90; c++) begin
        logic e;
        e = c[0];
        if (e) n++;
        apply(0, 0, e, 1, 16'h0000);
        chk($sformatf("toggle%0d", c), value, 16'((n / 10) << 4 | (n % 10)));
      end
    end

`ifdef BCD_CHAIN_LAP_EN
    // Lap freeze: display holds the snapshot while the count runs on.
    apply(0, 1, 0, 1, 16'h0012);
    lap = 1'b1;
    apply(0, 0, 0, 1, 16'h0000);
    lap = 1'b0;
    chk("lap_freeze_value", value, 16'h0012);
    chk("lap_freeze_active", {15'd0, lap_active}, 16'h0001);
    for (int c = 0; c < 5; c++) begin
      apply(0, 0, 1, 1, 16'h0000);
      chk($sformatf("lap_hold%0d", c), value, 16'h0012);
      chk($sformatf("lap_hold_active%0d", c), {15'd0, lap_active}, 16'h0001);
    end
    lap = 1'b1;
    apply(0, 0, 1, 1, 16'h0000);
    lap = 1'b0;
    chk("lap_release_value", value, 16'h0018);
    chk("lap_release_active", {15'd0, lap_active}, 16'h0000);
    // Clear drops the freeze.
    lap = 1'b1;
    apply(0, 0, 0, 1, 16'h0000);
    lap = 1'b0;
    apply(1, 0, 0, 1, 16'h0000);
    chk("lap_clear_active", {15'd0, lap_active}, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
